// File: rtl/ysyx_23060236_ifetch_refill.sv
// ysyx_23060236_ifetch_refill: icache probe front end with 8-beat AXI4 line refill
// and single-beat uncached bypass for instruction fetch.
module ysyx_23060236_ifetch_refill #(
    parameter logic [6:0] CACHE_BASE = 7'h50
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_inst,
    output logic        resp_err,
    output logic [24:0] icache_araddr,
    input  logic [31:0] icache_rdata,
    input  logic        icache_hit,
    output logic [24:0] icache_awaddr,
    output logic [31:0] icache_wdata,
    output logic        icache_wvalid,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast
);
    localparam logic [2:0] IDLE = 3'd0, LOOKUP = 3'd1, AR = 3'd2, R = 3'd3, RESP = 3'd4;
    logic [2:0]  r_state;
    logic [31:0] r_addr;
    logic [31:0] r_inst;
    logic        r_cacheable;
    logic        r_err;
    logic [2:0]  r_beat_cnt;
    logic        w_beat;
    logic        w_hit;
    assign w_beat        = (r_state == R) && rvalid;
    assign w_hit         = r_cacheable && icache_hit;
    assign req_ready     = r_state == IDLE;
    assign arvalid       = r_state == AR;
    assign rready        = r_state == R;
    assign resp_valid    = r_state == RESP;
    assign resp_inst     = r_inst;
    assign resp_err      = r_err;
    assign araddr        = r_cacheable ? {r_addr[31:5], 5'b0} : {r_addr[31:2], 2'b0};
    assign arlen         = r_cacheable ? 8'd7 : 8'd0;
    assign arsize        = 3'b010;
    assign arburst       = 2'b01;
    assign icache_araddr = r_addr[24:0];
    assign icache_awaddr = {r_addr[24:5], r_beat_cnt, 2'b0};
    assign icache_wdata  = rdata;
    assign icache_wvalid = w_beat && r_cacheable;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_inst      <= '0;
            r_cacheable <= 1'b0;
            r_err       <= 1'b0;
            r_beat_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_addr      <= req_addr;
                    r_cacheable <= req_addr[31:25] == CACHE_BASE;
                    r_beat_cnt  <= '0;
                    r_err       <= 1'b0;
                    r_state     <= LOOKUP;
                end
                LOOKUP: begin
                    if (w_hit) r_inst <= icache_rdata;
                    r_state <= w_hit ? RESP : AR;
                end
                AR: if (arready) r_state <= R;
                // every beat is written to the line; only the requested word is returned
                R: if (rvalid) begin
                    if (!r_cacheable || r_beat_cnt == r_addr[4:2]) r_inst <= rdata;
                    r_err      <= r_err | (rresp != 2'b00);
                    r_beat_cnt <= r_beat_cnt + 3'd1;
                    if (rlast) r_state <= RESP;
                end
                RESP: if (resp_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060236_ifetch_refill.sv
// tb_ysyx_23060236_ifetch_refill: directed bench with a one-line icache model and
// a scripted AXI slave whose word at byte address x is 0xA0000000 + x[24:2].
module tb_ysyx_23060236_ifetch_refill;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_inst;
    logic        resp_err;
    logic [24:0] icache_araddr;
    logic [31:0] icache_rdata;
    logic        icache_hit;
    logic [24:0] icache_awaddr;
    logic [31:0] icache_wdata;
    logic        icache_wvalid;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0;

    int n_chk = 0;
    int n_pass = 0;
    int n_wr = 0;
    int n_ar = 0;

    logic [31:0] line [8];
    logic [19:0] line_tag = '0;
    logic        line_valid = 1'b0;

    ysyx_23060236_ifetch_refill dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inst(resp_inst), .resp_err(resp_err),
        .icache_araddr(icache_araddr), .icache_rdata(icache_rdata), .icache_hit(icache_hit),
        .icache_awaddr(icache_awaddr), .icache_wdata(icache_wdata), .icache_wvalid(icache_wvalid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    always #5 clock = ~clock;

    assign icache_hit   = line_valid && (icache_araddr[24:5] == line_tag);
    assign icache_rdata = line[icache_araddr[4:2]];

    always @(posedge clock) if (icache_wvalid) begin
        line[icache_awaddr[4:2]] <= icache_wdata;
        line_tag   <= icache_awaddr[24:5];
        line_valid <= 1'b1;
    end

    always @(negedge clock) begin
        if (icache_wvalid) n_wr++;
        if (arvalid) n_ar++;
    end

    function automatic logic [31:0] mem(input logic [31:0] x);
        return 32'hA000_0000 + 32'(x[24:2]);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_arvalid"}, arvalid, 0);
        check({tag, "_rready"}, rready, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_wvalid"}, icache_wvalid, 0);
        check({tag, "_araddr"}, araddr, 0);
        check({tag, "_awaddr"}, icache_awaddr, 0);
        check({tag, "_resp_inst"}, resp_inst, 0);
        check({tag, "_resp_err"}, resp_err, 0);
    endtask

    task automatic issue(input logic [31:0] a);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = a;
        step();
        req_valid = 1'b0;
    endtask

    task automatic finish_resp(input logic [31:0] exp_inst, input logic exp_err, input int resp_wait);
        check("resp_valid", resp_valid, 1);
        check("resp_inst", resp_inst, exp_inst);
        check("resp_err", resp_err, exp_err);
        for (int k = 0; k < resp_wait; k++) begin
            step();
            check("resp_hold_valid", resp_valid, 1);
            check("resp_hold_inst", resp_inst, exp_inst);
            check("resp_hold_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("resp_done_valid", resp_valid, 0);
        check("resp_done_req_ready", req_ready, 1);
    endtask

    // miss or bypass fetch; rst_beat >= 0 pulses reset during that beat
    task automatic fetch(input logic [31:0] a, input int ar_wait, input logic [7:0] gaps,
                         input int err_beat, input int rst_beat, input int resp_wait);
        logic        cach;
        int          nb;
        int          w0;
        logic [31:0] exp_ar;
        logic [24:0] aw;
        cach   = a[31:25] == 7'h50;
        nb     = cach ? 8 : 1;
        exp_ar = cach ? {a[31:5], 5'b0} : {a[31:2], 2'b0};
        w0     = n_wr;
        issue(a);
        check("lookup_arvalid", arvalid, 0);
        step();
        check("ar_arvalid", arvalid, 1);
        check("ar_araddr", araddr, exp_ar);
        check("ar_arlen", arlen, cach ? 8'd7 : 8'd0);
        check("ar_arsize", arsize, 3'b010);
        check("ar_arburst", arburst, 2'b01);
        for (int k = 0; k < ar_wait; k++) begin
            step();
            check("ar_wait_valid", arvalid, 1);
            check("ar_wait_araddr", araddr, exp_ar);
            check("ar_wait_arlen", arlen, cach ? 8'd7 : 8'd0);
        end
        arready = 1'b1;
        step();
        arready = 1'b0;
        check("r_rready", rready, 1);
        check("r_arvalid", arvalid, 0);
        for (int b = 0; b < nb; b++) begin
            if (gaps[b]) begin
                aw = icache_awaddr;
                rvalid = 1'b0;
                step();
                check("gap_awaddr_hold", icache_awaddr, aw);
                check("gap_wvalid", icache_wvalid, 0);
                check("gap_rready", rready, 1);
            end
            rvalid = 1'b1;
            rdata  = mem(cach ? exp_ar + 32'(b * 4) : exp_ar);
            rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            rlast  = b == nb - 1;
            #1;
            check("beat_wvalid", icache_wvalid, cach);
            if (cach) begin
                check("beat_awaddr", icache_awaddr, {a[24:5], 3'(b), 2'b0});
                check("beat_wdata", icache_wdata, rdata);
            end
            if (b == rst_beat) begin
                reset = 1'b1;
                #1;
                check_reset_outputs("async_rst");
                rvalid = 1'b0;
                rlast  = 1'b0;
                rresp  = 2'b00;
                #1;
                reset = 1'b0;
                step();
                check("post_rst_idle", req_ready, 1);
                return;
            end
            step();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        check("write_count", n_wr - w0, cach ? 8 : 0);
        finish_resp(mem({a[31:2], 2'b0}), err_beat >= 0 && err_beat < nb, resp_wait);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, %0d/%0d checks passed before it", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int a0;
        #2;
        check_reset_outputs("reset");
        step();
        step();
        reset = 1'b0;
        step();
        check("idle_req_ready", req_ready, 1);
        check("idle_arvalid", arvalid, 0);

        fetch(32'ha000_0014, 0, 8'h00, -1, -1, 0);

        a0 = n_ar;
        issue(32'ha000_0018);
        check("hit_lookup_resp_valid", resp_valid, 0);
        step();
        check("hit_no_ar", n_ar - a0, 0);
        finish_resp(32'hA000_0006, 1'b0, 0);

        fetch(32'h3000_0004, 0, 8'h00, -1, -1, 0);
        fetch(32'ha000_0104, 5, 8'h48, -1, -1, 4);
        fetch(32'ha000_0208, 0, 8'h00, 2, -1, 0);
        fetch(32'ha000_0300, 0, 8'h00, -1, 4, 0);
        fetch(32'ha000_040c, 1, 8'h00, -1, -1, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
